rob_retire_ctrl: RTL and testbench
==================================

# rob_retire_ctrl

In-order retirement controller (reorder buffer) that produces the four-wide retire stream consumed by the architectural rename-state table. It accepts up to four renamed instructions per cycle from dispatch and tracks completion reports from four write-back ports. Each cycle it retires the oldest completed prefix of up to four entries as RetireRegNAble/RetireARNAddr/RetirePRNAddr. On an excepting head entry it flushes itself and asserts ReMapping so the speculative map can be restored from architectural state.

## Interface
- ROBDEEP, 32, number of entries (power of two, ≥8)
- ROBPTRW, 5, log2(ROBDEEP)
- PHYRPTRW, 7, physical register tag width
- Clk  in  1  single clock, all state on rising edge
- Rest  in  1  reset; synchronous and active-high (Rest=1 resets on the next Clk edge)
- DispNValid, N=1..4  in  1  dispatch slot N valid; valids contiguous from slot 1 (1, 1-2, 1-3, 1-4)
- DispNRegAble  in  1  slot N writes a destination register
- DispNArchReg  in  5  architectural destination
- DispNPhyReg  in  PHYRPTRW  allocated physical destination
- DispatchReady  out  1  dispatch accepted this cycle
- AllocTag  out  ROBPTRW  tag of slot 1; slot N receives (AllocTag+N-1) mod ROBDEEP
- WbNValid, N=1..4  in  1  completion report valid
- WbNTag  in  ROBPTRW  completing entry
- WbNExcp  in  1  entry raised an exception
- RetireRegNAble, N=1..4  out  1  registered; slot N retires a register mapping; slot 1 is the oldest
- RetireARNAddr  out  5  registered architectural register
- RetirePRNAddr  out  PHYRPTRW  registered physical register
- RetireCount  out  3  registered count of entries retired, 0..4
- ReMapping  out  1  one-cycle restore request to the architectural state table
- FlushOut  out  1  one-cycle front-end and back-end flush, coincident with ReMapping

## Operation
- Storage per entry: Valid, Complete, Excp, RegAble, ArchReg, PhyReg. Pointers: Head, Tail (ROBPTRW bits, wrap mod ROBDEEP). Occupancy count: ROBPTRW+1 bits, 0..ROBDEEP.
- FSM states: RUN, DRAIN, REMAP. Reset state is RUN.
- DispatchReady = (state==RUN) && (Count ≤ ROBDEEP-4) && !Rest.
- Dispatch: when DispatchReady=1, each valid slot writes the entry at Tail+N-1 with Valid=1 and Complete=0. Tail advances by the number of valid slots. Any RegAble with ArchReg==0 is stored as 0. When DispatchReady=0, dispatch inputs are ignored.
- Completion: WbNValid sets Complete=1 and Excp=WbNExcp on entry WbNTag only if that entry is Valid. Reports to invalid entries are ignored. Two ports reporting the same tag are ORed.
- Retire selection (RUN only): scan window Head..Head+3. Slot k retires if it is Valid, Complete, !Excp, and all older window slots retire. Outputs are packed in age order. RetireRegNAble=RegAble. Non-retiring slots drive 0 on all fields. Retired entries are cleared and Head advances by RetireCount.
- Exception: the first non-retiring window slot is Valid, Complete, and Excp. The older prefix retires normally that cycle. The excepting entry does not retire. All entries are invalidated, Head=Tail=0, Count=0, and the FSM goes to DRAIN.
- DRAIN lasts one cycle: the last retire outputs are visible, then the FSM goes to REMAP.
- REMAP lasts one cycle: ReMapping=1, FlushOut=1, retire outputs 0. The FSM then returns to RUN.
- Dispatch and retire in the same cycle: Count ← Count + dispatched − retired.

## Timing
- Reset: all retire outputs, RetireCount, ReMapping, and FlushOut are 0. DispatchReady=0 while Rest=1. AllocTag=0. Every entry is invalid. Reset in DRAIN or REMAP aborts to RUN without a ReMapping pulse.
- Write-back in cycle C sets Complete at the edge ending C. Retire selection happens in C+1. Retire outputs are visible in C+2. The architectural table is written at the end of C+2.
- Exception selected in cycle C: final retire outputs appear in C+1 (DRAIN). ReMapping and FlushOut pulse in C+2, so the architectural table already includes the C+1 retires. DispatchReady=1 again in C+3.
- Full: Count=ROBDEEP-3..ROBDEEP gives DispatchReady=0. Retirement continues and ready reasserts combinationally once Count ≤ ROBDEEP-4.
- Empty: RetireCount=0 and all retire outputs are 0.
- Wrap: the window and allocation indices wrap mod ROBDEEP. Head=ROBDEEP-2 retiring 4 leaves Head=2.

## Test plan
- Reset, then dispatch 4 (AR 1..4, PR 33..36). Complete all in one cycle -> two cycles later RetireCount=4, slot1 AR1/PR33 … slot4 AR4/PR36. Head=4.
- Complete tags 0,2,3 but not 1 -> only entry 0 retires (RetireCount=1). Completing tag 1 later -> tags 1..3 retire together.
- Fill to 29 entries -> DispatchReady=0. Retire 4 -> ready returns. Check wrap from Head=30 to Head=2.
- Entry 2 completes with Excp, entries 0 and 1 completed -> entries 0 and 1 retire in DRAIN. ReMapping=FlushOut=1 for exactly one cycle after. Then Count=0, AllocTag=0, and ready again.
- Entry with RegAble=0 (and another with ArchReg=0) completes -> it retires, RetireCount counts it, and RetireRegNAble=0.
- Assert Rest during DRAIN -> no ReMapping pulse. All outputs are 0 the next cycle and the FSM is in RUN.

Source files
------------

// File: rtl/rob_retire_ctrl.sv
//==============================================================================
// rob_retire_ctrl -- four-wide in-order retirement controller (reorder buffer)
// Rev 1.0 -- initial release
//==============================================================================
`default_nettype none

module rob_retire_ctrl #(
    parameter int ROBDEEP  = 32,
    parameter int ROBPTRW  = 5,
    parameter int PHYRPTRW = 7
) (
    input  logic                Clk,
    input  logic                Rest,
    input  logic                Disp1Valid,
    input  logic                Disp1RegAble,
    input  logic [4:0]          Disp1ArchReg,
    input  logic [PHYRPTRW-1:0] Disp1PhyReg,
    input  logic                Disp2Valid,
    input  logic                Disp2RegAble,
    input  logic [4:0]          Disp2ArchReg,
    input  logic [PHYRPTRW-1:0] Disp2PhyReg,
    input  logic                Disp3Valid,
    input  logic                Disp3RegAble,
    input  logic [4:0]          Disp3ArchReg,
    input  logic [PHYRPTRW-1:0] Disp3PhyReg,
    input  logic                Disp4Valid,
    input  logic                Disp4RegAble,
    input  logic [4:0]          Disp4ArchReg,
    input  logic [PHYRPTRW-1:0] Disp4PhyReg,
    output logic                DispatchReady,
    output logic [ROBPTRW-1:0]  AllocTag,
    input  logic                Wb1Valid,
    input  logic [ROBPTRW-1:0]  Wb1Tag,
    input  logic                Wb1Excp,
    input  logic                Wb2Valid,
    input  logic [ROBPTRW-1:0]  Wb2Tag,
    input  logic                Wb2Excp,
    input  logic                Wb3Valid,
    input  logic [ROBPTRW-1:0]  Wb3Tag,
    input  logic                Wb3Excp,
    input  logic                Wb4Valid,
    input  logic [ROBPTRW-1:0]  Wb4Tag,
    input  logic                Wb4Excp,
    output logic                RetireReg1Able,
    output logic [4:0]          RetireAR1Addr,
    output logic [PHYRPTRW-1:0] RetirePR1Addr,
    output logic                RetireReg2Able,
    output logic [4:0]          RetireAR2Addr,
    output logic [PHYRPTRW-1:0] RetirePR2Addr,
    output logic                RetireReg3Able,
    output logic [4:0]          RetireAR3Addr,
    output logic [PHYRPTRW-1:0] RetirePR3Addr,
    output logic                RetireReg4Able,
    output logic [4:0]          RetireAR4Addr,
    output logic [PHYRPTRW-1:0] RetirePR4Addr,
    output logic [2:0]          RetireCount,
    output logic                ReMapping,
    output logic                FlushOut
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        REMAP = 2'd2
    } state_t;

    localparam logic [ROBPTRW:0] READY_MAX = (ROBPTRW+1)'(ROBDEEP - 4);

    state_t                state_q, state_d;
    logic [ROBDEEP-1:0]    valid_q, valid_d, comp_q, comp_d, excp_q, excp_d, rega_q, rega_d;
    logic [4:0]            arch_q [ROBDEEP];
    logic [4:0]            arch_d [ROBDEEP];
    logic [PHYRPTRW-1:0]   phy_q  [ROBDEEP];
    logic [PHYRPTRW-1:0]   phy_d  [ROBDEEP];
    logic [ROBPTRW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [ROBPTRW:0]      count_q, count_d;
    logic [3:0]            oreg_q, oreg_d;
    logic [4:0]            oarch_q [4];
    logic [4:0]            oarch_d [4];
    logic [PHYRPTRW-1:0]   ophy_q  [4];
    logic [PHYRPTRW-1:0]   ophy_d  [4];
    logic [2:0]            ocnt_q, ocnt_d;

    logic [3:0]            disp_vld, disp_rega, wb_vld, wb_excp;
    logic [4:0]            disp_arch [4];
    logic [PHYRPTRW-1:0]   disp_phy  [4];
    logic [ROBPTRW-1:0]    wb_tag    [4];
    logic [ROBPTRW-1:0]    win_idx   [4];
    logic [ROBPTRW-1:0]    wr_idx;
    logic [3:0]            ret_mask;
    logic [2:0]            ret_cnt, disp_cnt;
    logic                  exc_hit, older_ok;

    assign disp_vld  = {Disp4Valid, Disp3Valid, Disp2Valid, Disp1Valid};
    assign disp_rega = {Disp4RegAble, Disp3RegAble, Disp2RegAble, Disp1RegAble};
    assign disp_arch[0] = Disp1ArchReg;
    assign disp_arch[1] = Disp2ArchReg;
    assign disp_arch[2] = Disp3ArchReg;
    assign disp_arch[3] = Disp4ArchReg;
    assign disp_phy[0]  = Disp1PhyReg;
    assign disp_phy[1]  = Disp2PhyReg;
    assign disp_phy[2]  = Disp3PhyReg;
    assign disp_phy[3]  = Disp4PhyReg;
    assign wb_vld  = {Wb4Valid, Wb3Valid, Wb2Valid, Wb1Valid};
    assign wb_excp = {Wb4Excp, Wb3Excp, Wb2Excp, Wb1Excp};
    assign wb_tag[0] = Wb1Tag;
    assign wb_tag[1] = Wb2Tag;
    assign wb_tag[2] = Wb3Tag;
    assign wb_tag[3] = Wb4Tag;

    assign disp_cnt = 3'(disp_vld[0]) + 3'(disp_vld[1]) + 3'(disp_vld[2]) + 3'(disp_vld[3]);

    assign DispatchReady = (state_q == RUN) && (count_q <= READY_MAX) && !Rest;
    assign AllocTag      = tail_q;

    // Oldest-first scan: a slot retires only if every older window slot retires.
    always_comb begin
        older_ok = (state_q == RUN);
        exc_hit  = 1'b0;
        ret_mask = '0;
        ret_cnt  = '0;
        for (int k = 0; k < 4; k++) begin
            win_idx[k] = head_q + ROBPTRW'(k);
            if (older_ok && valid_q[win_idx[k]] && comp_q[win_idx[k]]) begin
                if (excp_q[win_idx[k]]) begin
                    exc_hit  = 1'b1;
                    older_ok = 1'b0;
                end else begin
                    ret_mask[k] = 1'b1;
                    ret_cnt     = ret_cnt + 3'd1;
                end
            end else begin
                older_ok = 1'b0;
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        comp_d  = comp_q;
        excp_d  = excp_q;
        rega_d  = rega_q;
        arch_d  = arch_q;
        phy_d   = phy_q;
        head_d  = head_q + ROBPTRW'(ret_cnt);
        tail_d  = tail_q;
        count_d = count_q - (ROBPTRW+1)'(ret_cnt);
        state_d = state_q;
        wr_idx  = '0;

        // Same-cycle reports to one tag: last writer clears, then all OR in.
        for (int k = 0; k < 4; k++) begin
            if (wb_vld[k] && valid_q[wb_tag[k]]) begin
                comp_d[wb_tag[k]] = 1'b1;
                excp_d[wb_tag[k]] = 1'b0;
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (wb_vld[k] && valid_q[wb_tag[k]] && wb_excp[k]) begin
                excp_d[wb_tag[k]] = 1'b1;
            end
        end

        for (int k = 0; k < 4; k++) begin
            if (ret_mask[k]) begin
                valid_d[win_idx[k]] = 1'b0;
                comp_d[win_idx[k]]  = 1'b0;
                excp_d[win_idx[k]]  = 1'b0;
            end
        end

        if (DispatchReady) begin
            for (int k = 0; k < 4; k++) begin
                if (disp_vld[k]) begin
                    wr_idx          = tail_q + ROBPTRW'(k);
                    valid_d[wr_idx] = 1'b1;
                    comp_d[wr_idx]  = 1'b0;
                    excp_d[wr_idx]  = 1'b0;
                    rega_d[wr_idx]  = disp_rega[k] && (disp_arch[k] != 5'd0);
                    arch_d[wr_idx]  = disp_arch[k];
                    phy_d[wr_idx]   = disp_phy[k];
                end
            end
            tail_d  = tail_q + ROBPTRW'(disp_cnt);
            count_d = count_q + (ROBPTRW+1)'(disp_cnt) - (ROBPTRW+1)'(ret_cnt);
        end

        for (int k = 0; k < 4; k++) begin
            oreg_d[k]  = ret_mask[k] & rega_q[win_idx[k]];
            oarch_d[k] = ret_mask[k] ? arch_q[win_idx[k]] : 5'd0;
            ophy_d[k]  = ret_mask[k] ? phy_q[win_idx[k]] : '0;
        end
        ocnt_d = ret_cnt;

        case (state_q)
            RUN: begin
                if (exc_hit) begin
                    state_d = DRAIN;
                    valid_d = '0;
                    comp_d  = '0;
                    excp_d  = '0;
                    head_d  = '0;
                    tail_d  = '0;
                    count_d = '0;
                end
            end
            DRAIN:   state_d = REMAP;
            REMAP:   state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rest) begin
            state_q <= RUN;
            valid_q <= '0;
            comp_q  <= '0;
            excp_q  <= '0;
            rega_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            oreg_q  <= '0;
            oarch_q <= '{default: '0};
            ophy_q  <= '{default: '0};
            ocnt_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            comp_q  <= comp_d;
            excp_q  <= excp_d;
            rega_q  <= rega_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            oreg_q  <= oreg_d;
            oarch_q <= oarch_d;
            ophy_q  <= ophy_d;
            ocnt_q  <= ocnt_d;
        end
    end

    // Payload is qualified by valid_q, so it needs no reset.
    always_ff @(posedge Clk) begin
        arch_q <= arch_d;
        phy_q  <= phy_d;
    end

    assign RetireReg1Able = oreg_q[0];
    assign RetireReg2Able = oreg_q[1];
    assign RetireReg3Able = oreg_q[2];
    assign RetireReg4Able = oreg_q[3];
    assign RetireAR1Addr  = oarch_q[0];
    assign RetireAR2Addr  = oarch_q[1];
    assign RetireAR3Addr  = oarch_q[2];
    assign RetireAR4Addr  = oarch_q[3];
    assign RetirePR1Addr  = ophy_q[0];
    assign RetirePR2Addr  = ophy_q[1];
    assign RetirePR3Addr  = ophy_q[2];
    assign RetirePR4Addr  = ophy_q[3];
    assign RetireCount    = ocnt_q;
    assign ReMapping      = (state_q == REMAP);
    assign FlushOut       = (state_q == REMAP);

endmodule

`default_nettype wire

// File: tb/tb_rob_retire_ctrl.sv
//==============================================================================
// tb_rob_retire_ctrl -- scoreboard bench with a queue-based reorder-buffer model
// Rev 1.0 -- initial release
//==============================================================================
`default_nettype none

module tb_rob_retire_ctrl;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic       Rest;
    logic       d_vld [4];
    logic       d_rega[4];
    logic [4:0] d_ar  [4];
    logic [6:0] d_pr  [4];
    logic       w_vld [4];
    logic       w_ex  [4];
    logic [4:0] w_tag [4];

    wire        DispatchReady;
    wire [4:0]  AllocTag;
    wire [3:0]  r_able;
    wire [19:0] r_ar;
    wire [27:0] r_pr;
    wire [2:0]  RetireCount;
    wire        ReMapping;
    wire        FlushOut;

    rob_retire_ctrl #(.ROBDEEP(32), .ROBPTRW(5), .PHYRPTRW(7)) dut (
        .Clk(Clk), .Rest(Rest),
        .Disp1Valid(d_vld[0]), .Disp1RegAble(d_rega[0]), .Disp1ArchReg(d_ar[0]), .Disp1PhyReg(d_pr[0]),
        .Disp2Valid(d_vld[1]), .Disp2RegAble(d_rega[1]), .Disp2ArchReg(d_ar[1]), .Disp2PhyReg(d_pr[1]),
        .Disp3Valid(d_vld[2]), .Disp3RegAble(d_rega[2]), .Disp3ArchReg(d_ar[2]), .Disp3PhyReg(d_pr[2]),
        .Disp4Valid(d_vld[3]), .Disp4RegAble(d_rega[3]), .Disp4ArchReg(d_ar[3]), .Disp4PhyReg(d_pr[3]),
        .DispatchReady(DispatchReady), .AllocTag(AllocTag),
        .Wb1Valid(w_vld[0]), .Wb1Tag(w_tag[0]), .Wb1Excp(w_ex[0]),
        .Wb2Valid(w_vld[1]), .Wb2Tag(w_tag[1]), .Wb2Excp(w_ex[1]),
        .Wb3Valid(w_vld[2]), .Wb3Tag(w_tag[2]), .Wb3Excp(w_ex[2]),
        .Wb4Valid(w_vld[3]), .Wb4Tag(w_tag[3]), .Wb4Excp(w_ex[3]),
        .RetireReg1Able(r_able[0]), .RetireAR1Addr(r_ar[4:0]),   .RetirePR1Addr(r_pr[6:0]),
        .RetireReg2Able(r_able[1]), .RetireAR2Addr(r_ar[9:5]),   .RetirePR2Addr(r_pr[13:7]),
        .RetireReg3Able(r_able[2]), .RetireAR3Addr(r_ar[14:10]), .RetirePR3Addr(r_pr[20:14]),
        .RetireReg4Able(r_able[3]), .RetireAR4Addr(r_ar[19:15]), .RetirePR4Addr(r_pr[27:21]),
        .RetireCount(RetireCount), .ReMapping(ReMapping), .FlushOut(FlushOut)
    );

    typedef struct {
        logic       rega;
        logic [4:0] ar;
        logic [6:0] pr;
        bit         comp;
        bit         excp;
    } ent_t;

    typedef struct {
        int          cyc;
        logic [56:0] v;
    } ev_t;

    // Model: the buffer is an age-ordered queue; tag of position p is (mhead+p) mod 32.
    ent_t rob[$];
    ev_t  evq[$];
    int   mhead  = 0;
    int   mstate = 0;   // 0 run, 1 drain, 2 remap
    int   cyc    = 0;
    int   total  = 0;
    int   bad    = 0;
    logic [56:0] mon_act;

    always @(posedge Clk) cyc <= cyc + 1;

    function automatic logic [56:0] mk_ev(bit rm, bit fl, int n, logic [3:0] able,
                                          logic [19:0] ar, logic [27:0] pr);
        return {rm, fl, 3'(n), able, ar, pr};
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents a retire/remap event.
    always @(negedge Clk) begin
        mon_act = {ReMapping, FlushOut, RetireCount, r_able, r_ar, r_pr};
        while (evq.size() > 0 && evq[0].cyc < cyc) begin
            total++;
            bad++;
            $display("FAIL missed_event cyc=%0d required=%h not presented", evq[0].cyc, evq[0].v);
            void'(evq.pop_front());
        end
        total++;
        if (evq.size() > 0 && evq[0].cyc == cyc) begin
            if (mon_act !== evq[0].v) begin
                bad++;
                $display("FAIL retire_event cyc=%0d actual=%h required=%h", cyc, mon_act, evq[0].v);
            end
            void'(evq.pop_front());
        end else if (mon_act !== 57'd0) begin
            bad++;
            $display("FAIL idle_outputs cyc=%0d actual=%h required=0", cyc, mon_act);
        end
    end

    task automatic model_step(input bit rdy);
        int          now;
        int          nret;
        int          pos;
        bit          exc;
        logic [3:0]  able;
        logic [19:0] ar;
        logic [27:0] pr;
        ent_t        e;
        now  = cyc;
        nret = 0;
        exc  = 0;
        able = '0;
        ar   = '0;
        pr   = '0;
        if (Rest) begin
            rob.delete();
            mhead  = 0;
            mstate = 0;
            while (evq.size() > 0 && evq[$].cyc > now) void'(evq.pop_back());
            return;
        end
        if (mstate == 0) begin
            for (int i = 0; i < 4 && i < rob.size(); i++) begin
                if (rob[i].comp && !rob[i].excp) begin
                    able[i]       = rob[i].rega;
                    ar[5*i +: 5]  = rob[i].ar;
                    pr[7*i +: 7]  = rob[i].pr;
                    nret++;
                end else begin
                    exc = rob[i].comp && rob[i].excp;
                    break;
                end
            end
        end
        for (int p = 0; p < 4; p++) begin
            pos = (int'(w_tag[p]) - mhead + 32) % 32;
            if (w_vld[p] && pos < rob.size()) begin
                e = rob[pos]; e.comp = 1; e.excp = 0; rob[pos] = e;
            end
        end
        for (int p = 0; p < 4; p++) begin
            pos = (int'(w_tag[p]) - mhead + 32) % 32;
            if (w_vld[p] && w_ex[p] && pos < rob.size()) begin
                e = rob[pos]; e.excp = 1; rob[pos] = e;
            end
        end
        if (mstate == 0) begin
            if (nret > 0) evq.push_back(ev_t'{now + 1, mk_ev(0, 0, nret, able, ar, pr)});
            if (exc) begin
                rob.delete();
                mhead  = 0;
                mstate = 1;
                evq.push_back(ev_t'{now + 2, mk_ev(1, 1, 0, 4'd0, 20'd0, 28'd0)});
                return;
            end
            repeat (nret) void'(rob.pop_front());
            mhead = (mhead + nret) % 32;
            if (rdy) begin
                for (int p = 0; p < 4; p++) begin
                    if (d_vld[p]) begin
                        e.rega = d_rega[p] && (d_ar[p] != 5'd0);
                        e.ar   = d_ar[p];
                        e.pr   = d_pr[p];
                        e.comp = 0;
                        e.excp = 0;
                        rob.push_back(e);
                    end
                end
            end
        end else if (mstate == 1) begin
            mstate = 2;
        end else begin
            mstate = 0;
        end
    endtask

    // Called right after inputs are driven at a falling edge.
    task automatic go();
        logic       exp_ready;
        logic [4:0] exp_tag;
        #1;
        exp_ready = !Rest && (mstate == 0) && (rob.size() <= 28);
        exp_tag   = 5'((mhead + rob.size()) % 32);
        total++;
        if (DispatchReady !== exp_ready) begin
            bad++;
            $display("FAIL dispatch_ready cyc=%0d actual=%b required=%b", cyc, DispatchReady, exp_ready);
        end
        if (!Rest) begin
            total++;
            if (AllocTag !== exp_tag) begin
                bad++;
                $display("FAIL alloc_tag cyc=%0d actual=%0d required=%0d", cyc, AllocTag, exp_tag);
            end
        end
        model_step(exp_ready);
        @(negedge Clk);
    endtask

    task automatic clr();
        Rest = 1'b0;
        for (int p = 0; p < 4; p++) begin
            d_vld[p] = 0; d_rega[p] = 0; d_ar[p] = '0; d_pr[p] = '0;
            w_vld[p] = 0; w_ex[p] = 0; w_tag[p] = '0;
        end
    endtask

    task automatic disp(input int n, input int ar0, input int pr0);
        for (int p = 0; p < n; p++) begin
            d_vld[p] = 1; d_rega[p] = 1; d_ar[p] = 5'(ar0 + p); d_pr[p] = 7'(pr0 + p);
        end
    endtask

    task automatic wbp(input int port, input int pos, input bit ex);
        w_vld[port] = 1;
        w_tag[port] = 5'((mhead + pos) % 32);
        w_ex[port]  = ex;
    endtask

    task automatic idle(input int n);
        repeat (n) begin clr(); go(); end
    endtask

    initial begin
        clr();
        Rest = 1'b1;
        @(negedge Clk);
        go(); go();

        // Four in, all complete together, four out.
        clr(); disp(4, 1, 33); go();
        clr(); for (int p = 0; p < 4; p++) wbp(p, p, 0); go();
        idle(3);

        // Hole at the second entry blocks younger completions.
        clr(); disp(4, 5, 40); go();
        clr(); wbp(0, 0, 0); wbp(1, 2, 0); wbp(2, 3, 0); go();
        idle(2);
        clr(); wbp(0, 0, 0); go();
        idle(3);

        // Excepting third entry: older two retire in DRAIN, then one remap pulse.
        clr(); disp(3, 9, 50); go();
        clr(); wbp(0, 0, 0); wbp(1, 1, 0); wbp(2, 2, 1); go();
        idle(5);

        // RegAble=0, and RegAble with ArchReg=0.
        clr(); disp(2, 0, 60); d_rega[0] = 0; d_ar[0] = 5'd7; d_ar[1] = 5'd0; go();
        clr(); wbp(0, 0, 0); wbp(1, 1, 0); go();
        idle(3);

        // Fill to 29, stall, drain in groups of four across the wrap point.
        repeat (7) begin clr(); disp(4, 1, 0); go(); end
        clr(); disp(1, 3, 100); go();
        repeat (2) begin clr(); disp(4, 2, 2); go(); end
        clr(); for (int p = 0; p < 4; p++) wbp(p, p, 0); go();
        idle(2);
        clr(); disp(4, 20, 80); go();
        repeat (9) begin
            clr(); for (int p = 0; p < 4; p++) wbp(p, p, 0); go();
            idle(2);
        end
        idle(2);

        // Reset while in DRAIN suppresses the remap pulse.
        clr(); disp(2, 11, 70); go();
        clr(); wbp(0, 0, 1); go();
        idle(1);
        clr(); Rest = 1'b1; go();
        idle(3);

        // Randomized traffic.
        repeat (3000) begin
            int n;
            int sz;
            clr();
            Rest = ($urandom_range(0, 299) == 0);
            n = $urandom_range(0, 4);
            for (int p = 0; p < n; p++) begin
                d_vld[p]  = 1;
                d_rega[p] = 1'($urandom_range(0, 1));
                d_ar[p]   = 5'($urandom_range(0, 31));
                d_pr[p]   = 7'($urandom_range(0, 127));
            end
            sz = rob.size();
            for (int p = 0; p < 4; p++) begin
                if ($urandom_range(0, 9) < 6) begin
                    if (sz > 0) wbp(p, $urandom_range(0, (sz > 8 ? 8 : sz) - 1), 0);
                    else begin w_vld[p] = 1; w_tag[p] = 5'($urandom_range(0, 31)); end
                    w_ex[p] = ($urandom_range(0, 39) == 0);
                end
            end
            go();
        end

        idle(10);
        total++;
        if (evq.size() != 0) begin
            bad++;
            $display("FAIL pending_events actual=%0d required=0", evq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
